// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants for the serial packed-BCD adder: digit width, the largest
// legal BCD digit, the decimal correction constant, the sequencer state
// encoding, and a helper that flags any non-BCD digit in a packed operand.
// -----------------------------------------------------------------------------
package bcd_pkg;

   localparam int DIGIT_W  = 4;
   localparam int BCD_MAX  = 9;
   localparam int BCD_CORR = 6;
   localparam int MAX_DIGITS = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADD  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      ADD  = ST_ADD,
      DONE = ST_DONE
   } state_e;

   // True when any of the lowest n digits of v is above 9. The operand is
   // passed zero-extended to the widest legal size so one function serves
   // every DIGITS value.
   function automatic logic any_invalid_digit(input logic [DIGIT_W*MAX_DIGITS-1:0] v,
                                              input int n);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < n && v[DIGIT_W*i +: DIGIT_W] > DIGIT_W'(BCD_MAX)) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

endpackage

// File: rtl/bcd.sv
// -----------------------------------------------------------------------------
// bcd
// One-digit BCD adder, purely combinational.
//   a, b   : input digits (values above 9 go through the same rule unchanged)
//   c_in   : carry in
//   sum    : corrected result digit
//   c_out  : decimal carry out (binary sum above 9)
// -----------------------------------------------------------------------------
module bcd
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               c_in,
   output logic [DIGIT_W-1:0] sum,
   output logic               c_out
);

   logic [DIGIT_W:0] raw;

   assign raw   = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, c_in};
   assign c_out = (raw > (DIGIT_W+1)'(BCD_MAX));
   // Adding 6 and dropping bit 4 skips the six unused codes A..F.
   assign sum   = raw[DIGIT_W-1:0] + (c_out ? DIGIT_W'(BCD_CORR) : {DIGIT_W{1'b0}});

endmodule

// File: rtl/bcd_serial_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_serial_ctrl
// Adds two DIGITS-digit packed-BCD operands with a single one-digit adder,
// one digit per clock, least-significant digit first.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, honoured only while idle
//   a, b      : packed BCD operands, digit 0 in bits [3:0]
//   c_in      : carry into digit 0
//   busy      : high during the digit-serial add
//   done      : one-cycle pulse; sum / c_out / err valid in that cycle
//   sum       : packed BCD result (held until the next capture)
//   c_out     : carry out of the top digit
//   err       : some captured operand digit was above 9
// -----------------------------------------------------------------------------
module bcd_serial_ctrl
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  c_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  c_out,
   output logic                  err
);

   localparam int W     = DIGIT_W * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_e             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               c_out_q, c_out_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [DIGIT_W-1:0] a_dig, b_dig, add_sum;
   logic               add_cout;

   // Operand digit select on idx.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_dig = a_q[DIGIT_W*i +: DIGIT_W];
            b_dig = b_q[DIGIT_W*i +: DIGIT_W];
         end
      end
   end

   bcd u_bcd (
      .a     (a_dig),
      .b     (b_dig),
      .c_in  (carry_q),
      .sum   (add_sum),
      .c_out (add_cout)
   );

   always_comb begin
      // NOTE: every _d takes its hold value first, so no path can leave one
      // unassigned and infer a latch.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      c_out_d = c_out_q;
      err_d   = err_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = c_in;
               sum_d   = '0;
               idx_d   = '0;
               err_d   = any_invalid_digit((DIGIT_W*MAX_DIGITS)'(a), DIGITS) |
                         any_invalid_digit((DIGIT_W*MAX_DIGITS)'(b), DIGITS);
               state_d = ADD;
            end
         end
         ADD: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  sum_d[DIGIT_W*i +: DIGIT_W] = add_sum;
               end
            end
            carry_d = add_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               c_out_d = add_cout;
               state_d = DONE;
            end
         end
         DONE: begin
            // start is deliberately not looked at here: no queued requests.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Flags are registered from the next state so they line up with it.
      busy_d = (state_d == ADD);
      done_d = (state_d == DONE);
   end

   // NOTE: state is updated with non-blocking assignments so every flop sees
   // the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: operand registers are plain flops, not a memory, so they are
         // reset with everything else and never feed X into the adder.
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         c_out_q <= c_out_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign err   = err_q;

endmodule

// File: tb/tb_bcd_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_ctrl
// Bench for bcd_serial_ctrl (DIGITS=4). A decimal reference model predicts
// busy/done on every cycle and sum/c_out/err whenever they are defined;
// directed operations pin known results with literal values.
// -----------------------------------------------------------------------------
module tb_bcd_serial_ctrl;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         c_in = 1'b0;
   logic         busy, done, c_out, err;
   logic [W-1:0] sum;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   bcd_serial_ctrl #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out),
      .err   (err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (decimal arithmetic) ----------------
   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
      int c;
      int raw;
      logic [W-1:0] s;
      c = int'(ci);
      s = '0;
      for (int i = 0; i < DIGITS; i++) begin
         raw = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + c;
         if (raw > 9) begin
            c   = 1;
            raw = raw + 6;
         end else begin
            c = 0;
         end
         s[4*i +: 4] = 4'(raw % 16);
      end
      return {c[0], s};
   endfunction

   function automatic logic ref_err(input logic [W-1:0] x, input logic [W-1:0] y);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // m_k counts edges since the last capture; above DIGITS means idle.
   int           m_k = DIGITS + 1;
   logic [W-1:0] m_pend_sum, exp_sum;
   logic         m_pend_cout, exp_cout, exp_err;

   always @(posedge clk) begin
      if (rst) begin
         m_k      = DIGITS + 1;
         exp_sum  = '0;
         exp_cout = 1'b0;
         exp_err  = 1'b0;
      end else if (m_k > DIGITS) begin
         if (start) begin
            {m_pend_cout, m_pend_sum} = ref_add(a, b, c_in);
            exp_err = ref_err(a, b);
            m_k     = 0;
         end
      end else begin
         m_k++;
         if (m_k == DIGITS) begin
            exp_sum  = m_pend_sum;
            exp_cout = m_pend_cout;
         end
      end
   end

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 64'(busy), 64'(m_k < DIGITS));
         check("done", 64'(done), 64'(m_k == DIGITS));
         check("err",  64'(err),  64'(exp_err));
         if (m_k >= DIGITS) begin
            check("sum",   64'(sum),   64'(exp_sum));
            check("c_out", 64'(c_out), 64'(exp_cout));
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_v; c_in = tc;
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
   endtask

   // Called on the negedge right after the capture edge; returns on the
   // negedge of the done cycle (or after the bound expires).
   task automatic wait_done(input string tag, output int busy_cnt, output bit got);
      busy_cnt = 0;
      got      = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         @(negedge clk);
      end
      check({tag, "_done_seen"}, 64'(got), 64'd1);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic [W-1:0] es, input logic ec,
                         input logic ee);
      int  bc;
      bit  got;
      issue(ta, tb_v, tc);
      wait_done(tag, bc, got);
      check({tag, "_busy_cycles"}, 64'(bc), 64'(DIGITS));
      check({tag, "_sum"},   64'(sum),   64'(es));
      check({tag, "_c_out"}, 64'(c_out), 64'(ec));
      check({tag, "_err"},   64'(err),   64'(ee));
   endtask

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v;
      for (int i = 0; i < DIGITS; i++) begin
         v[4*i +: 4] = ($urandom_range(7) == 0) ? 4'($urandom) : 4'($urandom_range(9));
      end
      return v;
   endfunction

   initial begin
      int  bc;
      bit  got;
      int  n_done;

      // Reset
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_busy",  64'(busy),  64'd0);
      check("reset_done",  64'(done),  64'd0);
      check("reset_sum",   64'(sum),   64'd0);
      check("reset_c_out", 64'(c_out), 64'd0);
      check("reset_err",   64'(err),   64'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Literal results
      run_op("op1234", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
      run_op("op9999", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("op0038", 16'h0038, 16'h0045, 1'b1, 16'h0084, 1'b0, 1'b0);
      run_op("op00A0", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
      run_op("opclean", 16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0);
      run_op("opFFFF", 16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 1'b1);

      // start in the 2nd ADD cycle is ignored and not queued
      issue(16'h0123, 16'h0456, 1'b0);
      @(negedge clk);
      start = 1'b1; a = 16'h9999; b = 16'h9999; c_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignore", bc, got);
      check("ignore_sum", 64'(sum), 64'h0579);
      n_done = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("ignore_no_second_done", 64'(n_done), 64'd0);

      // rst in the 3rd ADD cycle discards the operation
      issue(16'h4321, 16'h1111, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy",  64'(busy),  64'd0);
      check("midrst_done",  64'(done),  64'd0);
      check("midrst_sum",   64'(sum),   64'd0);
      check("midrst_c_out", 64'(c_out), 64'd0);
      check("midrst_err",   64'(err),   64'd0);
      rst = 1'b0;
      n_done = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("midrst_no_done", 64'(n_done), 64'd0);
      run_op("after_rst", 16'h2500, 16'h7500, 1'b0, 16'h0000, 1'b1, 1'b0);

      // start held high: one operation per DIGITS+2 cycles
      @(negedge clk);
      start = 1'b1; a = 16'h0001; b = 16'h0001; c_in = 1'b0;
      n_done = 0;
      repeat (2 * (DIGITS + 2)) begin
         @(negedge clk);
         if (done) n_done++;
      end
      start = 1'b0;
      check("held_start_dones", 64'(n_done), 64'd2);
      repeat (DIGITS + 2) @(negedge clk);

      // Random traffic, checked cycle by cycle against the model
      n_done = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         rst   = ($urandom_range(149) == 0);
         start = ($urandom_range(2) == 0);
         a     = rand_bcd();
         b     = rand_bcd();
         c_in  = 1'($urandom);
         if (done) n_done++;
      end
      rst   = 1'b0;
      start = 1'b0;
      repeat (DIGITS + 3) @(negedge clk);
      check("random_dones_seen", 64'(n_done > 100), 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
